dmem_access_ctrl: RTL

Memory-stage data-access controller for the pipelined MIPS core. It takes a load/store from the EX/MEM latch outputs, drives the data-cache request (dREN/dWEN/address/store data), holds the pipeline via a stall while the cache is busy, and presents the loaded word to the MEM/WB latch's dmemloadIN. It also tracks the LL/SC link register when compiled in.

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/dmem_access_ctrl_llsc_link.sv | 34 +++
 rtl/dmem_access_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipelined MIPS core: the machine word and the
// state encoding of the memory-stage data-access controller.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmemctl_state_t;

endpackage

// File: rtl/dmem_access_ctrl_llsc_link.sv
// LL/SC link register: remembers the word address of the last completed ll.
// A new ll always takes priority over any clearing event in the same cycle.
// Instantiated by dmem_access_ctrl only when LLSC_EN is defined.
module llsc_link (
    input  logic        clk,
    input  logic        rst,
    input  logic        setLink,
    input  logic        storeDone,
    input  logic        ccinv,
    input  logic [29:0] addr,
    input  logic [29:0] snoopAddr,
    output logic        link_match
);

    logic        linkValid;
    logic [29:0] linkAddr;

    assign link_match = linkValid && (linkAddr == addr);

    // Set on ll completion, clear on a store to the linked word or a matching snoop invalidate
    always_ff @(posedge clk) begin
        if (rst) begin
            linkValid <= 1'b0;
            linkAddr  <= '0;
        end else if (setLink) begin
            linkValid <= 1'b1;
            linkAddr  <= addr;
        end else if ((storeDone && link_match) ||
                     (ccinv && linkValid && (snoopAddr == linkAddr))) begin
            linkValid <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-access controller: issues the D-cache request for the
// load/store in EX/MEM, stalls the pipeline until the cache answers, and
// registers the loaded word for MEM/WB. Optional macro LLSC_EN adds the
// LL/SC link register (llsc_link); without it ll/sc behave as lw/sw.
module dmem_access_ctrl
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  renIN,
    input  logic  wenIN,
    input  logic  llIN,
    input  logic  scIN,
    input  word_t addrIN,
    input  word_t storeIN,
    input  logic  flush,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  ccinv,
    input  word_t ccsnoopaddr,
    output logic  dREN,
    output logic  dWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output logic  mem_stall,
    output word_t dmemloadOUT
);

    dmemctl_state_t state, nextState;

    logic  req, reqWrite, reqSc, reqLl, scFail;
    logic  opWrite, opSc, opLl;
    logic  curWrite, curSc, curLl;
    logic  complete, failDone;
    word_t captureData;

    assign req      = (renIN | wenIN) & ~flush;
    assign reqWrite = wenIN;
    assign reqSc    = wenIN & scIN;
    assign reqLl    = renIN & ~wenIN & llIN;

    assign dmemaddr  = {addrIN[31:2], 2'b00};
    assign dmemstore = storeIN;

    assign curWrite = (state == IDLE) ? reqWrite : opWrite;
    assign curSc    = (state == IDLE) ? reqSc    : opSc;
    assign curLl    = (state == IDLE) ? reqLl    : opLl;

    assign captureData = curWrite ? {31'b0, curSc} : dmemload;

`ifdef LLSC_EN
    logic linkMatch;
    logic unusedLowBits;

    assign scFail        = reqSc & ~linkMatch;
    assign unusedLowBits = ^{addrIN[1:0], ccsnoopaddr[1:0]};

    llsc_link uLink (
        .clk        (CLK),
        .rst        (RST),
        .setLink    (complete & curLl),
        .storeDone  (complete & curWrite),
        .ccinv      (ccinv),
        .addr       (addrIN[31:2]),
        .snoopAddr  (ccsnoopaddr[31:2]),
        .link_match (linkMatch)
    );
`else
    logic unusedLlscBits;

    assign scFail         = 1'b0;
    assign unusedLlscBits = ^{llIN, curLl, ccinv, ccsnoopaddr, addrIN[1:0]};
`endif

    // Request/stall outputs and next state; a failing sc skips the cache entirely
    always_comb begin
        nextState = state;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        mem_stall = 1'b0;
        complete  = 1'b0;
        failDone  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    mem_stall = 1'b1;
                    if (scFail) begin
                        failDone  = 1'b1;
                        nextState = DONE;
                    end else begin
                        dREN = ~reqWrite;
                        dWEN = reqWrite;
                        if (dhit) begin
                            complete  = 1'b1;
                            nextState = DONE;
                        end else begin
                            nextState = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                dREN      = ~opWrite;
                dWEN      = opWrite;
                if (dhit) begin
                    complete  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State, captured result, and the request kind frozen while waiting in BUSY
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            dmemloadOUT <= '0;
            opWrite     <= 1'b0;
            opSc        <= 1'b0;
            opLl        <= 1'b0;
        end else begin
            state <= nextState;
            if (complete) begin
                dmemloadOUT <= captureData;
            end else if (failDone) begin
                dmemloadOUT <= '0;
            end
            if (state == IDLE) begin
                opWrite <= reqWrite;
                opSc    <= reqSc;
                opLl    <= reqLl;
            end
        end
    end

endmodule
